// File: rtl/router_pkg.sv
// Shared types and helpers for demux_fifo_router.
// The optional occupancy port is enabled by ROUTER_OCCUPANCY_OUT_EN.
package router_pkg;

    // Control FSM encodings; the numeric values are visible to software.
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // A count must reach 2**ptr_l, so it needs one bit more than a pointer.
    function automatic int cnt_width(input int ptr_l);
        return ptr_l + 1;
    endfunction

endpackage

// File: rtl/thresh_fifo.sv
// One destination FIFO: storage, wrapping pointers, occupancy count,
// registered read port, almost-full/almost-empty flags and error pulses.
module thresh_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int PTR_L  = 2,
    localparam int CNT_W = cnt_width(PTR_L)
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_L-1:0]  thr_full_i,
    input  logic [PTR_L-1:0]  thr_empty_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int DEPTH = 1 << PTR_L;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_L-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              full, empty, push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign push_ok     = push_i && (!full || pop_i);
    // No bypass: a push into an empty FIFO cannot satisfy the same-cycle pop.
    assign pop_ok      = pop_i && !empty;
    assign overflow_o  = push_i && full && !pop_i;
    assign underflow_o = pop_i && empty;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop_ok)
            count_d = count_q - CNT_W'(1);
    end

    // Word storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the cleared pointers make stale words unreachable.
        if (push_ok && !reset_i)
            mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers, count and registered read port.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PTR_L'(1);
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_L'(1);
                rdata_q  <= mem_q[rd_ptr_q];
            end
            rvalid_q <= pop_ok;
            count_q  <= count_d;
        end
    end

    assign rdata_o        = rdata_q;
    assign rvalid_o       = rvalid_q;
    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= {1'b0, thr_full_i});
    assign almost_empty_o = (count_q <= {1'b0, thr_empty_i});

endmodule

// File: rtl/demux_fifo_router.sv
// Demultiplexes one word stream into NUM_DEST threshold FIFOs by the
// destination field in the word MSBs, with a status FSM and sticky errors.
// Define ROUTER_OCCUPANCY_OUT_EN to expose the per-destination counts.
module demux_fifo_router
    import router_pkg::*;
#(
    parameter int DATA_W    = 6,
    parameter int NUM_DEST  = 2,
    parameter int DEST_BITS = $clog2(NUM_DEST),
    parameter int PTR_L     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic [NUM_DEST*PTR_L-1:0]    umbral_full,
    input  logic [NUM_DEST*PTR_L-1:0]    umbral_empty,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         push_data_in,
    input  logic [NUM_DEST-1:0]          pop,
    output logic [NUM_DEST*DATA_W-1:0]   data_out,
    output logic [NUM_DEST-1:0]          valid_out,
    output logic [NUM_DEST-1:0]          almost_full,
    output logic [NUM_DEST-1:0]          almost_empty,
    output logic                         pause,
    output logic [NUM_DEST-1:0]          errors,
    output logic                         error_out,
    output logic                         active_out,
    output logic                         idle_out
`ifdef ROUTER_OCCUPANCY_OUT_EN
    ,
    output logic [NUM_DEST*(PTR_L+1)-1:0] occupancy
`endif
);

    localparam int CNT_W = cnt_width(PTR_L);

    state_t                      state_q, state_d;
    logic [NUM_DEST*PTR_L-1:0]   thr_full_q, thr_empty_q;
    logic [NUM_DEST-1:0]         errors_q, errors_d;
    logic [NUM_DEST-1:0]         overflow, underflow;
    logic [NUM_DEST*CNT_W-1:0]   cnt_flat;
    logic [DEST_BITS-1:0]        dest;
    logic                        accept, any_count, err_new;
    logic                        error_q, active_q, idle_q;

    assign dest      = data_in[DATA_W-1 -: DEST_BITS];
    assign accept    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign any_count = |cnt_flat;
    assign err_new   = |((overflow | underflow) & ~errors_q);

    for (genvar d = 0; d < NUM_DEST; d++) begin : g_fifo
        thresh_fifo #(
            .DATA_W (DATA_W),
            .PTR_L  (PTR_L)
        ) u_fifo (
            .clk            (clk),
            .reset_i        (reset),
            .push_i         (push_data_in && accept && (dest == DEST_BITS'(d))),
            .pop_i          (pop[d]),
            .wdata_i        (data_in),
            .thr_full_i     (thr_full_q[d*PTR_L +: PTR_L]),
            .thr_empty_i    (thr_empty_q[d*PTR_L +: PTR_L]),
            .rdata_o        (data_out[d*DATA_W +: DATA_W]),
            .rvalid_o       (valid_out[d]),
            .count_o        (cnt_flat[d*CNT_W +: CNT_W]),
            .almost_full_o  (almost_full[d]),
            .almost_empty_o (almost_empty[d]),
            .overflow_o     (overflow[d]),
            .underflow_o    (underflow[d])
        );
    end

    // Thresholds follow the inputs for as long as the FSM sits in INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            thr_full_q  <= '0;
            thr_empty_q <= '0;
        end else if (state_q == ST_INIT) begin
            thr_full_q  <= umbral_full;
            thr_empty_q <= umbral_empty;
        end
    end

    // Sticky errors; leaving ERROR through INIT wipes them.
    always_comb begin
        errors_d = errors_q | overflow | underflow;
        if ((state_q == ST_ERROR) && init)
            errors_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            errors_q <= '0;
        else
            errors_q <= errors_d;
    end

    // Next-state selection; init outranks a same-cycle error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)                           state_d = ST_INIT;
                else if (err_new)                   state_d = ST_ERROR;
                else if (push_data_in || any_count) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                             state_d = ST_INIT;
                else if (err_new)                     state_d = ST_ERROR;
                else if (!any_count && !push_data_in) state_d = ST_IDLE;
            end
            ST_ERROR:  if (init) state_d = ST_INIT;
            default:   state_d = ST_RESET;
        endcase
    end

    // State register with status outputs registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RESET;
            error_q  <= 1'b0;
            active_q <= 1'b0;
            idle_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            error_q  <= (state_d == ST_ERROR);
            active_q <= (state_d == ST_ACTIVE);
            idle_q   <= (state_d == ST_IDLE);
        end
    end

    assign errors     = errors_q;
    assign pause      = |almost_full;
    assign error_out  = error_q;
    assign active_out = active_q;
    assign idle_out   = idle_q;

`ifdef ROUTER_OCCUPANCY_OUT_EN
    assign occupancy = cnt_flat;
`endif

endmodule

// File: doc/demux_fifo_router.md
Name: demux_fifo_router

Overview:
- Parametrised successor of the two-destination interconnect device.
- A single input word stream is demultiplexed by its destination field into NUM_DEST independent output FIFOs.
- Each FIFO has programmable almost-full and almost-empty thresholds; almost-full back-pressures upstream through `pause`.
- A control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) reports device status. The block sits between the upstream producer and NUM_DEST downstream consumers.

Parameters:
- DATA_W, 6, word width including the destination field.
- NUM_DEST, 2, number of destination FIFOs (power of 2, ≥2).
- DEST_BITS, $clog2(NUM_DEST), width of the destination field, taken from the word MSBs.
- PTR_L, 2, pointer width; FIFO depth = 2**PTR_L.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  requests threshold (re)load.
- umbral_full  in  NUM_DEST*PTR_L  packed per-dest almost-full thresholds; dest d at [d*PTR_L +: PTR_L].
- umbral_empty  in  NUM_DEST*PTR_L  packed per-dest almost-empty thresholds.
- data_in  in  DATA_W  input word.
- push_data_in  in  1  write strobe.
- pop  in  NUM_DEST  per-dest read strobe.
- data_out  out  NUM_DEST*DATA_W  per-dest registered read data.
- valid_out  out  NUM_DEST  per-dest read-data valid.
- almost_full  out  NUM_DEST
- almost_empty  out  NUM_DEST
- pause  out  1  OR of almost_full.
- errors  out  NUM_DEST  sticky per-dest overflow/underflow flags.
- error_out, active_out, idle_out  out  1 each  FSM status.

Behaviour:
- Reset (reset=1 at an edge):
  - All pointers, counts, data_out, valid_out and errors are cleared to 0.
  - Latched thresholds are cleared to 0. State = RESET; all status outputs are 0.
- Routing:
  - d = data_in[DATA_W-1 -: DEST_BITS]; the full word, including the field, is stored.
  - A push is accepted only in IDLE or ACTIVE; it is ignored in RESET, INIT and ERROR.
- Count: width PTR_L+1, range 0..2**PTR_L. Pointers wrap modulo depth.
- Full, push: the word is dropped and errors[d] is set.
- Simultaneous push and pop on a full FIFO: both succeed and count is unchanged.
- Pop on empty: ignored, errors[d] set, valid_out[d]=0. Push+pop on an empty FIFO: the push is stored, the pop is flagged as underflow (no bypass).
- Read latency: pop sampled at edge N gives data_out/valid_out at edge N. Values are held until the next pop; valid_out is a 1-cycle pulse.
- almost_full[d] = count ≥ umbral_full_lat[d]. almost_empty[d] = count ≤ umbral_empty_lat[d]. Both are combinational from registered state.
- FSM:
  - RESET→INIT on the first edge with reset=0.
  - INIT: thresholds are latched every cycle; INIT→IDLE when init=0.
  - IDLE→ACTIVE on an accepted push or when any count≠0.
  - ACTIVE→IDLE when all counts=0 and there is no push.
  - Any new errors bit (IDLE/ACTIVE)→ERROR.
  - IDLE/ACTIVE/ERROR with init=1→INIT. Entering INIT from ERROR clears errors; FIFO contents are kept.
  - Reset takes priority over all transitions.
- Status outputs: idle_out=(IDLE), active_out=(ACTIVE), error_out=(ERROR).

Optional Feature:
- Macro ROUTER_OCCUPANCY_OUT_EN.
- Defined: adds output port `occupancy`, width NUM_DEST*(PTR_L+1), exposing the registered per-dest counts.
- Undefined: the port is absent; behaviour is otherwise identical.

Decomposition:
- Package router_pkg:
  - FSM state typedef/encodings: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; 3 bits.
  - Helper localparam for count width.
- Sub-module thresh_fifo:
  - One FIFO holding storage, pointers, count and registered read port.
  - Flags: almost flags, overflow/underflow pulse.
  - Instantiated NUM_DEST times via generate.

Test Plan:
Defaults throughout; thresholds full=3, empty=1.
1. Reset then init:
   - Stimulus: reset=1 for 2 cycles; release with init=0.
   - Response: during reset all outputs 0; one INIT cycle; then idle_out=1 and almost_empty=2'b11.
2. Routing:
   - Stimulus: push 6'b111111, then 6'b011110.
   - Response: count1=1, count0=1, active_out=1; pop=2'b11 gives data_out1=6'b111111 and data_out0=6'b011110 with valid_out=2'b11 one edge later.
3. Back-pressure:
   - Stimulus: push 6'h01, 6'h02, 6'h03 to dest0.
   - Response: after the third edge almost_full[0]=1, pause=1.
4. Overflow:
   - Stimulus: push 5 words to dest0 with no pops.
   - Response: the 5th word is dropped, count0=4, errors=2'b01, error_out=1 next cycle. init=1 then clears errors and returns to INIT.
5. Drain:
   - Stimulus: pop dest0 while almost_empty[0]=0.
   - Response: data in order 01, 02, 03; stops with count0=1. A pop on empty sets errors[0].
6. Reset mid-traffic:
   - Stimulus: reset=1 with both FIFOs partially full.
   - Response: all counts 0 and status 0 next edge.
